// File: rtl/pwm_dac.sv
// 8-bit PWM DAC: free-running 256-clock period, single-entry sample buffer,
// duty updated at the period boundary, underrun detection with saturating count.
module pwm_dac #(
  parameter int HOLD_LAST = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        pwm_out,
  output logic        period_start,
  output logic        underrun,
  output logic [15:0] underrun_count
);

  logic [7:0] cnt;
  logic [7:0] duty;
  logic [7:0] pending;
  logic       pend_valid;
  logic       accept;
  logic       boundary;

  assign sample_ready = !rst && !pend_valid;
  assign accept       = sample_valid && sample_ready;
  assign boundary     = (cnt == 8'd255);
  assign period_start = (cnt == 8'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt            <= 8'd0;
      duty           <= 8'd128;
      pending        <= 8'd0;
      pend_valid     <= 1'b0;
      pwm_out        <= 1'b0;
      underrun       <= 1'b0;
      underrun_count <= 16'd0;
    end else begin
      cnt      <= cnt + 8'd1;
      pwm_out  <= (cnt < duty);
      underrun <= boundary && !pend_valid;
      // accept only happens with the buffer empty, so it never collides
      // with the boundary transfer below
      if (accept) begin
        pending    <= sample_in;
        pend_valid <= 1'b1;
      end
      if (boundary) begin
        if (pend_valid) begin
          duty       <= pending;
          pend_valid <= 1'b0;
        end else begin
          if (HOLD_LAST == 0) duty <= 8'd128;
          if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Directed bench for pwm_dac: reset, load, extremes, backpressure, underrun,
// streamed samples with a mid-period reset.
module tb_pwm_dac;
  localparam int HOLD = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sample_in = 8'd0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        pwm_out;
  logic        period_start;
  logic        underrun;
  logic [15:0] underrun_count;

  int checks = 0;
  int fails  = 0;

  pwm_dac #(.HOLD_LAST(HOLD)) dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .pwm_out(pwm_out), .period_start(period_start),
    .underrun(underrun), .underrun_count(underrun_count)
  );

  always #10 clk = ~clk;  // 50 MHz

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
  endtask

  task automatic sync_ps();
    int n = 0;
    while (!period_start && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (period_start !== 1'b1) begin
      fails++;
      $display("FAIL sync_timeout: period_start=%b after %0d cycles, want 1", period_start, n);
    end
  endtask

  // Call at a cnt==0 sample point; spans cnt 1..255,0 and returns counts of
  // pwm/ready/underrun/period_start high over those 256 cycles.
  task automatic measure(input logic nv, input logic [7:0] nd,
                         output int hi, output int rdy, output int und, output int ps);
    hi = 0; rdy = 0; und = 0; ps = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 0) begin
        sample_valid = nv;
        sample_in    = nd;
      end
      hi  += int'(pwm_out);
      rdy += int'(sample_ready);
      und += int'(underrun);
      ps  += int'(period_start);
    end
  endtask

  task automatic send(input logic [7:0] v);
    int n = 0;
    sample_valid = 1'b1;
    sample_in    = v;
    while (!sample_ready && n < 600) begin
      step();
      n++;
    end
    checks++;
    if (sample_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_timeout: sample_ready=%b, want 1", sample_ready);
    end
    step();
    sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    int hi, rdy, und, ps;
    #55 rst = 1'b0;
    #1;
    checks++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
    checks++; if (period_start !== 1'b1) begin fails++; $display("FAIL rst_ps: got %b want 1", period_start); end
    checks++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", sample_ready); end
    checks++; if (underrun !== 1'b0) begin fails++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    checks++; if (underrun_count !== 16'd0) begin fails++; $display("FAIL rst_ucount: got %0d want 0", underrun_count); end
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 128) begin fails++; $display("FAIL rst_duty128: high %0d want 128", hi); end
    checks++; if (ps != 1) begin fails++; $display("FAIL rst_ps_per_period: got %0d want 1", ps); end
    checks++; if (und != 1) begin fails++; $display("FAIL rst_first_underrun: pulses %0d want 1", und); end
    checks++; if (underrun_count !== 16'd1) begin fails++; $display("FAIL rst_ucount_after: got %0d want 1", underrun_count); end
  endtask

  task automatic test_load();
    int hi, rdy, und, ps;
    do_reset();
    send(8'd64);
    checks++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL load_ready_low: got %b want 0", sample_ready); end
    sync_ps();
    checks++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL load_ready_high: got %b want 1", sample_ready); end
    checks++; if (underrun_count !== 16'd0) begin fails++; $display("FAIL load_ucount: got %0d want 0", underrun_count); end
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 64) begin fails++; $display("FAIL load_duty64: high %0d want 64", hi); end
  endtask

  task automatic test_extremes();
    int hi, rdy, und, ps;
    do_reset();
    send(8'd0);
    sync_ps();
    sample_valid = 1'b1;
    sample_in    = 8'd255;
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 0) begin fails++; $display("FAIL ext_duty0: high %0d want 0", hi); end
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 255) begin fails++; $display("FAIL ext_duty255: high %0d want 255 (1 low)", hi); end
  endtask

  task automatic test_back_to_back();
    int hi, rdy, und, ps;
    do_reset();
    sample_valid = 1'b1;
    sample_in    = 8'd10;
    step();
    sample_in = 8'd20;
    checks++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL b2b_ready_low: got %b want 0", sample_ready); end
    sync_ps();
    measure(1'b1, 8'd30, hi, rdy, und, ps);
    checks++; if (hi != 10) begin fails++; $display("FAIL b2b_duty10: high %0d want 10", hi); end
    checks++; if (rdy != 1) begin fails++; $display("FAIL b2b_ready_cycles1: got %0d want 1", rdy); end
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 20) begin fails++; $display("FAIL b2b_duty20: high %0d want 20", hi); end
    checks++; if (rdy != 1) begin fails++; $display("FAIL b2b_ready_cycles2: got %0d want 1", rdy); end
    checks++; if (underrun_count !== 16'd0) begin fails++; $display("FAIL b2b_ucount: got %0d want 0", underrun_count); end
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 30) begin fails++; $display("FAIL b2b_duty30: high %0d want 30", hi); end
  endtask

  task automatic test_underrun();
    int hi, rdy, und, ps, tot;
    int exp_hi;
    do_reset();
    send(8'd77);
    sync_ps();
    tot = 0;
    for (int p = 0; p < 3; p++) begin
      measure(1'b0, 8'd0, hi, rdy, und, ps);
      tot += und;
      exp_hi = (p == 0 || HOLD == 1) ? 77 : 128;
      checks++;
      if (hi != exp_hi) begin fails++; $display("FAIL und_duty_p%0d: high %0d want %0d", p, hi, exp_hi); end
    end
    checks++; if (tot != 3) begin fails++; $display("FAIL und_pulses: got %0d want 3", tot); end
    checks++; if (underrun_count !== 16'd3) begin fails++; $display("FAIL und_count: got %0d want 3", underrun_count); end
  endtask

  task automatic test_stream_reset();
    int hi, rdy, und, ps;
    logic [7:0] sine [3];
    sine[0] = 8'd218; sine[1] = 8'd255; sine[2] = 8'd37;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      send(sine[i]);
      sync_ps();
      measure(1'b0, 8'd0, hi, rdy, und, ps);
      checks++;
      if (hi != int'(sine[i])) begin fails++; $display("FAIL stream_%0d: high %0d want %0d", i, hi, sine[i]); end
    end
    send(8'd200);
    repeat (99) step();  // now at cnt==100 with 200 pending
    sample_valid = 1'b1;
    sample_in    = 8'd99;
    rst = 1'b1;
    #1;
    checks++; if (sample_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_ready: got %b want 0", sample_ready); end
    step();
    rst = 1'b0;
    sample_valid = 1'b0;
    #1;
    checks++; if (period_start !== 1'b1) begin fails++; $display("FAIL mid_rst_ps: got %b want 1", period_start); end
    checks++; if (sample_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_ready_rel: got %b want 1", sample_ready); end
    checks++; if (underrun_count !== 16'd0) begin fails++; $display("FAIL mid_rst_ucount: got %0d want 0", underrun_count); end
    checks++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL mid_rst_pwm: got %b want 0", pwm_out); end
    measure(1'b0, 8'd0, hi, rdy, und, ps);
    checks++; if (hi != 128) begin fails++; $display("FAIL mid_rst_duty: high %0d want 128", hi); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_extremes();
    test_back_to_back();
    test_underrun();
    test_stream_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
